mac_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit. It is the next generation of the fixed 8x8/16-bit MAC and adds configurable operand and accumulator widths, a valid handshake with pipeline bubbles, an explicit accumulator clear, and overflow detection with optional saturation. It sits in the datapath wherever a running dot-product or FIR-tap sum is needed, fed one operand pair per cycle by a streaming source.

---
 rtl/mac_pkg.sv | 11 +
 rtl/mac_sat_add.sv | 26 ++
 rtl/mac_pipe.sv | 63 ++++++
 tb/tb_mac_pipe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: default MAC widths and signed range helpers shared by the mac_pipe slice.
package mac_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF = 16;
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: signed accumulator adder with overflow flag; clamps when MAC_SATURATE_EN is defined.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int AW = ACC_WIDTH_DEF
) (
    input  logic signed [AW-1:0] x,
    input  logic signed [AW-1:0] y,
    output logic signed [AW-1:0] sum,
    output logic                 ovf
);
`ifdef MAC_SATURATE_EN
    localparam logic [AW-1:0] MAX = AW'(sat_max(AW));
    localparam logic [AW-1:0] MIN = AW'(sat_min(AW));
`endif
    logic signed [AW-1:0] raw;
    always_comb begin
        raw = x + y;
        ovf = (x[AW-1] == y[AW-1]) && (raw[AW-1] != x[AW-1]);
`ifdef MAC_SATURATE_EN
        sum = ovf ? (x[AW-1] ? MIN : MAX) : raw;
`else
        sum = raw;
`endif
    end
endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: 3-stage pipelined signed MAC with clear, bubbles and sticky overflow (saturating with MAC_SATURATE_EN).
module mac_pipe
    import mac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_in,
    input  logic                        clear_in,
    input  logic signed [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    output logic signed [ACC_WIDTH-1:0] f,
    output logic                        valid_out,
    output logic                        overflow
);
    if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_width
        $error("mac_pipe: ACC_WIDTH must be >= 2*WIDTH");
    end
    logic signed [WIDTH-1:0]     a_r, b_r;
    logic                        v1, c1, v2, c2;
    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0] p_r, sum;
    logic                        ovf;
    assign prod = a_r * b_r;
    mac_sat_add #(.AW(ACC_WIDTH)) u_add (
        .x  (f),
        .y  (p_r),
        .sum(sum),
        .ovf(ovf)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r       <= '0;
            b_r       <= '0;
            v1        <= 1'b0;
            c1        <= 1'b0;
            p_r       <= '0;
            v2        <= 1'b0;
            c2        <= 1'b0;
            f         <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            a_r       <= a;
            b_r       <= b;
            v1        <= valid_in;
            c1        <= clear_in;
            p_r       <= ACC_WIDTH'(prod);
            v2        <= v1;
            c2        <= c1;
            valid_out <= v2;
            if (c2) begin
                f        <= v2 ? p_r : '0;
                overflow <= 1'b0;
            end else if (v2) begin
                f        <= sum;
                overflow <= overflow | ovf;
            end
        end
    end
endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: directed and random checks of mac_pipe against an arithmetic reference model.
module tb_mac_pipe;
    localparam int W = 8;
    localparam int AW = 16;
    localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AW - 1));
    localparam longint RANGE = longint'(1) <<< AW;
    logic clk = 1'b0;
    logic reset = 1'b0, valid_in = 1'b0, clear_in = 1'b0;
    logic signed [W-1:0] a = '0, b = '0;
    logic signed [AW-1:0] f;
    logic valid_out, overflow;
    int checks = 0, errors = 0;
    typedef struct {logic v; logic c; int a; int b;} smp_t;
    smp_t q[$];
    smp_t zs;
    longint mf = 0;
    logic mv = 1'b0, mo = 1'b0;

    mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clear_in(clear_in),
        .a(a), .b(b), .f(f), .valid_out(valid_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample reaches the accumulator two edges after capture; the queue models that delay.
    task automatic apply(input smp_t s);
        longint t;
        mv = s.v;
        if (s.c) begin
            mf = s.v ? longint'(s.a) * s.b : 0;
            mo = 1'b0;
        end else if (s.v) begin
            t = mf + longint'(s.a) * s.b;
            if (t > MAXV || t < MINV) begin
                mo = 1'b1;
`ifdef MAC_SATURATE_EN
                t = (t > MAXV) ? MAXV : MINV;
`else
                t = ((t - MINV) % RANGE + RANGE) % RANGE + MINV;
`endif
            end
            mf = t;
        end
    endtask

    task automatic cyc(input logic v, input logic c, input int av, input int bv, input logic r);
        smp_t s;
        valid_in = v;
        clear_in = c;
        a = W'(av);
        b = W'(bv);
        reset = r;
        @(posedge clk);
        if (r) begin
            q = {zs, zs};
            mf = 0;
            mv = 1'b0;
            mo = 1'b0;
        end else begin
            s.v = v; s.c = c; s.a = av; s.b = bv;
            q.push_back(s);
            apply(q.pop_front());
        end
        #1;
        chk("model_f", longint'(f), mf);
        chk("model_valid", longint'(valid_out), longint'(mv));
        chk("model_ovf", longint'(overflow), longint'(mo));
    endtask

    initial begin
        zs.v = 1'b0; zs.c = 1'b0; zs.a = 0; zs.b = 0;
        // reset held with live inputs
        cyc(1, 0, 5, 5, 1);
        cyc(1, 0, 5, 5, 1);
        chk("reset_f", longint'(f), 0);
        chk("reset_valid", longint'(valid_out), 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("post_reset_f", longint'(f), 0);
        chk("post_reset_valid", longint'(valid_out), 0);
        chk("post_reset_ovf", longint'(overflow), 0);
        // accumulate
        cyc(1, 1, 3, 4, 0);
        cyc(1, 0, -2, 5, 0);
        cyc(0, 0, 0, 0, 0);
        chk("acc_12", longint'(f), 12);
        chk("acc_12_valid", longint'(valid_out), 1);
        cyc(0, 0, 0, 0, 0);
        chk("acc_2", longint'(f), 2);
        chk("acc_2_valid", longint'(valid_out), 1);
        // bubble then clear
        cyc(1, 1, 3, 4, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0);
        chk("bub_12", longint'(f), 12);
        cyc(0, 0, 0, 0, 0);
        chk("bub_hold", longint'(f), 12);
        chk("bub_hold_valid", longint'(valid_out), 0);
        cyc(0, 0, 0, 0, 0);
        chk("bub_13", longint'(f), 13);
        cyc(1, 1, 7, 7, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("clr_49", longint'(f), 49);
        // positive overflow
        cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, 127, 127, 0);
        chk("pos_1", longint'(f), 16129);
        cyc(0, 0, 0, 0, 0);
        chk("pos_2", longint'(f), 32258);
        chk("pos_2_ovf", longint'(overflow), 0);
        cyc(0, 0, 0, 0, 0);
`ifdef MAC_SATURATE_EN
        chk("pos_3", longint'(f), 32767);
`else
        chk("pos_3", longint'(f), -17149);
`endif
        chk("pos_3_ovf", longint'(overflow), 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("clr_only_f", longint'(f), 0);
        chk("clr_only_ovf", longint'(overflow), 0);
        chk("clr_only_valid", longint'(valid_out), 0);
        // negative overflow
        cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, -128, 127, 0);
        chk("neg_1", longint'(f), -16256);
        cyc(0, 0, 0, 0, 0);
        chk("neg_2", longint'(f), -32512);
        cyc(0, 0, 0, 0, 0);
`ifdef MAC_SATURATE_EN
        chk("neg_3", longint'(f), -32768);
`else
        chk("neg_3", longint'(f), 16768);
`endif
        chk("neg_3_ovf", longint'(overflow), 1);
        // reset mid-stream
        cyc(1, 1, 9, 9, 0);
        cyc(1, 0, 2, 3, 0);
        cyc(1, 0, 4, 4, 1);
        repeat (3) begin
            cyc(0, 0, 0, 0, 0);
            chk("mid_reset_valid", longint'(valid_out), 0);
            chk("mid_reset_f", longint'(f), 0);
        end
        // random stream
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                1'($urandom_range(0, 63) == 0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
